// File: rtl/ts_sync_aligner.sv
`default_nettype none
// ============================================================================
//  Module   : ts_sync_aligner
//  Purpose  : Acquires and tracks 188-byte MPEG-TS packet alignment on the
//             0x47 sync byte. Only whole, aligned packets are written to the
//             TS FIFO, each byte tagged with its 1-based position in the packet.
//  Revision : 1.0  initial release
// ============================================================================
module ts_sync_aligner #(
    parameter int LOCK_COUNT   = 3,
    parameter int UNLOCK_COUNT = 3,
    parameter int MIN_ROOM     = 192
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  DIN,
    input  logic        DIN_VALID,
    input  logic [10:0] FIFO_ROOM,
    output logic        WR_REQ,
    output logic [7:0]  WR_DATA,
    output logic [7:0]  WR_INDEX,
    output logic        SYNC_FOUND,
    output logic [15:0] DROP_CNT,
    output logic [7:0]  LOSS_CNT,
    output logic [1:0]  state_mon
);

    localparam logic [1:0] S_SEARCH  = 2'd0;
    localparam logic [1:0] S_VERIFY  = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;
    localparam logic [7:0] SYNC_BYTE = 8'h47;
    localparam logic [7:0] LAST_POS  = 8'd187;

    logic [1:0]  state_q, state_d;
    logic [7:0]  pos_q, pos_d;
    logic [3:0]  hits_q, hits_d;
    logic [3:0]  miss_q, miss_d;
    logic        accept_q, accept_d;

    logic        wr_req_q, wr_req_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [7:0]  wr_index_q, wr_index_d;
    logic        sync_q, sync_d;
    logic [15:0] drop_q, drop_d;
    logic [7:0]  loss_q, loss_d;

    // Shared decode of the current byte against the tracked alignment.
    logic       at_sync_w, is_sync_w, room_ok_w;
    logic       lock_now_w, unlock_now_w, admit_w;
    logic [3:0] hits_inc_w, miss_inc_w;
    logic [7:0] pos_next_w;

    assign at_sync_w    = (pos_q == 8'd0);
    assign is_sync_w    = (DIN == SYNC_BYTE);
    assign room_ok_w    = (FIFO_ROOM >= 11'(MIN_ROOM));
    assign hits_inc_w   = (hits_q == 4'hF) ? hits_q : hits_q + 4'd1;
    assign miss_inc_w   = (miss_q == 4'hF) ? miss_q : miss_q + 4'd1;
    assign pos_next_w   = (pos_q == LAST_POS) ? 8'd0 : pos_q + 8'd1;
    assign lock_now_w   = DIN_VALID && (state_q == S_VERIFY) && at_sync_w &&
                          is_sync_w && (hits_inc_w >= 4'(LOCK_COUNT));
    assign unlock_now_w = DIN_VALID && (state_q == S_LOCKED) && at_sync_w &&
                          !is_sync_w && (miss_inc_w >= 4'(UNLOCK_COUNT));
    // A packet admission decision is taken at every sync position handled in LOCKED,
    // including the sync byte that completes acquisition.
    assign admit_w      = DIN_VALID && at_sync_w &&
                          (lock_now_w || ((state_q == S_LOCKED) && !unlock_now_w));

    // State register: alignment tracking state and admission flag.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_SEARCH;
            pos_q    <= 8'd0;
            hits_q   <= 4'd0;
            miss_q   <= 4'd0;
            accept_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            hits_q   <= hits_d;
            miss_q   <= miss_d;
            accept_q <= accept_d;
        end
    end

    // Next-state logic: search, verify candidate alignment, track lock.
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        hits_d   = hits_q;
        miss_d   = miss_q;
        accept_d = accept_q;
        if (DIN_VALID) begin
            case (state_q)
                S_SEARCH: begin
                    if (is_sync_w) begin
                        state_d = S_VERIFY;
                        hits_d  = 4'd1;
                        pos_d   = 8'd1;
                    end
                end
                S_VERIFY: begin
                    if (at_sync_w && !is_sync_w) begin
                        // The failing byte is not reconsidered as a new candidate.
                        state_d = S_SEARCH;
                        pos_d   = 8'd0;
                        hits_d  = 4'd0;
                    end else begin
                        pos_d = pos_next_w;
                        if (at_sync_w) begin
                            hits_d = hits_inc_w;
                        end
                        if (lock_now_w) begin
                            state_d = S_LOCKED;
                            miss_d  = 4'd0;
                        end
                    end
                end
                S_LOCKED: begin
                    if (unlock_now_w) begin
                        state_d  = S_SEARCH;
                        pos_d    = 8'd0;
                        hits_d   = 4'd0;
                        miss_d   = 4'd0;
                        accept_d = 1'b0;
                    end else begin
                        pos_d = pos_next_w;
                        if (at_sync_w) begin
                            miss_d = is_sync_w ? 4'd0 : miss_inc_w;
                        end
                    end
                end
                default: begin
                    state_d  = S_SEARCH;
                    pos_d    = 8'd0;
                    hits_d   = 4'd0;
                    miss_d   = 4'd0;
                    accept_d = 1'b0;
                end
            endcase
            if (admit_w) begin
                accept_d = room_ok_w;
            end
        end
    end

    // Output logic: FIFO write, corrected sync byte, drop/loss statistics.
    always_comb begin
        wr_req_d   = 1'b0;
        wr_data_d  = wr_data_q;
        wr_index_d = wr_index_q;
        drop_d     = drop_q;
        loss_d     = loss_q;
        sync_d     = (state_d == S_LOCKED);
        if (admit_w) begin
            if (room_ok_w) begin
                // A sync byte is always written as 0x47, even when tolerated as a miss.
                wr_req_d   = 1'b1;
                wr_data_d  = SYNC_BYTE;
                wr_index_d = 8'd1;
            end else if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
        end else if (DIN_VALID && (state_q == S_LOCKED) && !at_sync_w && accept_q) begin
            wr_req_d   = 1'b1;
            wr_data_d  = DIN;
            wr_index_d = pos_q + 8'd1;
        end
        if (unlock_now_w && (loss_q != 8'hFF)) begin
            loss_d = loss_q + 8'd1;
        end
    end

    // Output registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_req_q   <= 1'b0;
            wr_data_q  <= 8'd0;
            wr_index_q <= 8'd0;
            sync_q     <= 1'b0;
            drop_q     <= 16'd0;
            loss_q     <= 8'd0;
        end else begin
            wr_req_q   <= wr_req_d;
            wr_data_q  <= wr_data_d;
            wr_index_q <= wr_index_d;
            sync_q     <= sync_d;
            drop_q     <= drop_d;
            loss_q     <= loss_d;
        end
    end

    assign WR_REQ     = wr_req_q;
    assign WR_DATA    = wr_data_q;
    assign WR_INDEX   = wr_index_q;
    assign SYNC_FOUND = sync_q;
    assign DROP_CNT   = drop_q;
    assign LOSS_CNT   = loss_q;
    assign state_mon  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ts_sync_aligner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ts_sync_aligner
//  Purpose  : Scoreboard bench for ts_sync_aligner. A packet-level reference
//             model walks the byte stream by 188-byte strides and queues the
//             expected FIFO writes; a monitor pops them as the DUT writes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ts_sync_aligner;

    localparam int LOCK   = 3;
    localparam int UNLOCK = 3;
    localparam int MINR   = 192;
    localparam int PKT    = 188;

    logic        CLK;
    logic        RST;
    logic [7:0]  DIN;
    logic        DIN_VALID;
    logic [10:0] FIFO_ROOM;
    logic        WR_REQ;
    logic [7:0]  WR_DATA;
    logic [7:0]  WR_INDEX;
    logic        SYNC_FOUND;
    logic [15:0] DROP_CNT;
    logic [7:0]  LOSS_CNT;
    logic [1:0]  state_mon;

    ts_sync_aligner #(
        .LOCK_COUNT   (LOCK),
        .UNLOCK_COUNT (UNLOCK),
        .MIN_ROOM     (MINR)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .DIN        (DIN),
        .DIN_VALID  (DIN_VALID),
        .FIFO_ROOM  (FIFO_ROOM),
        .WR_REQ     (WR_REQ),
        .WR_DATA    (WR_DATA),
        .WR_INDEX   (WR_INDEX),
        .SYNC_FOUND (SYNC_FOUND),
        .DROP_CNT   (DROP_CNT),
        .LOSS_CNT   (LOSS_CNT),
        .state_mon  (state_mon)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] idx;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  s_data[$];
    logic [10:0] s_room[$];
    int          total = 0;
    int          bad   = 0;
    int          n_wr  = 0;

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // Monitor: every DUT write is matched against the head of the scoreboard.
    initial begin
        forever begin
            @(negedge CLK);
            if (RST && WR_REQ) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wr_extra: got write data=%0d idx=%0d expected none",
                             WR_DATA, WR_INDEX);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_data", int'(WR_DATA), int'(e.data));
                    check("wr_index", int'(WR_INDEX), int'(e.idx));
                    check("wr_sync_found", int'(SYNC_FOUND), 1);
                end
            end
        end
    end

    function automatic logic [7:0] rnd_byte(input bit allow47);
        logic [7:0] b;
        if (allow47) begin
            b = 8'($urandom_range(0, 255));
        end else begin
            b = 8'($urandom_range(0, 254));
            if (b >= 8'h47) b = b + 8'd1;
        end
        return b;
    endfunction

    // Build npk aligned packets; sync positions get ample room, other bytes random room.
    task automatic build(input int npk, input bit allow47);
        s_data.delete();
        s_room.delete();
        for (int p = 0; p < npk; p++) begin
            for (int b = 0; b < PKT; b++) begin
                s_data.push_back((b == 0) ? 8'h47 : rnd_byte(allow47));
                s_room.push_back((b == 0) ? 11'd2000 : 11'($urandom_range(0, 2047)));
            end
        end
    endtask

    // Reference model: locate candidates, verify by 188-byte strides, then walk
    // packets while locked. Returns final state code and counter values.
    task automatic model_run(output int m_state, output int m_drop, output int m_loss);
        int n, i, j, s, hits, miss;
        bit locked, unlocked;
        n = s_data.size();
        i = 0;
        m_state = 0;
        m_drop  = 0;
        m_loss  = 0;
        while (i < n) begin
            m_state = 0;
            while (i < n && s_data[i] != 8'h47) i++;
            if (i >= n) break;
            m_state = 1;
            hits    = 1;
            locked  = 0;
            j       = i + PKT;
            while (j < n) begin
                if (s_data[j] != 8'h47) break;
                hits++;
                if (hits >= LOCK) begin
                    locked = 1;
                    break;
                end
                j += PKT;
            end
            if (j >= n) break;
            if (!locked) begin
                i = j + 1;
                continue;
            end
            m_state  = 2;
            miss     = 0;
            unlocked = 0;
            for (s = j; s < n; s += PKT) begin
                if (s_data[s] != 8'h47) begin
                    miss++;
                    if (miss >= UNLOCK) begin
                        if (m_loss < 255) m_loss++;
                        unlocked = 1;
                        break;
                    end
                end else begin
                    miss = 0;
                end
                if (int'(s_room[s]) >= MINR) begin
                    for (int k = 0; k < PKT && s + k < n; k++) begin
                        wr_t e;
                        e.data = (k == 0) ? 8'h47 : s_data[s + k];
                        e.idx  = 8'(k + 1);
                        exp_q.push_back(e);
                    end
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
            end
            if (!unlocked) break;
            m_state = 0;
            i = s + 1;
        end
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_wr_req"}, int'(WR_REQ), 0);
        check({nm, "_wr_data"}, int'(WR_DATA), 0);
        check({nm, "_wr_index"}, int'(WR_INDEX), 0);
        check({nm, "_sync_found"}, int'(SYNC_FOUND), 0);
        check({nm, "_drop_cnt"}, int'(DROP_CNT), 0);
        check({nm, "_loss_cnt"}, int'(LOSS_CNT), 0);
        check({nm, "_state_mon"}, int'(state_mon), 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #1;
        RST       = 1'b0;
        DIN_VALID = 1'b0;
        #1;
        check_zero("rst");
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
    endtask

    // Present each stream byte once, with optional idle cycles in front of it.
    task automatic drive_all(input int gap_pct);
        for (int k = 0; k < s_data.size(); k++) begin
            for (int g = 0; g < 3 && int'($urandom_range(0, 99)) < gap_pct; g++) begin
                DIN_VALID = 1'b0;
                DIN       = 8'h47;
                FIFO_ROOM = 11'($urandom_range(0, 2047));
                @(posedge CLK);
                #1;
            end
            DIN       = s_data[k];
            FIFO_ROOM = s_room[k];
            DIN_VALID = 1'b1;
            @(posedge CLK);
            #1;
            DIN_VALID = 1'b0;
        end
    endtask

    task automatic run_scn(input string nm, input int gap_pct);
        int ms, md, ml;
        do_reset();
        n_wr = 0;
        model_run(ms, md, ml);
        drive_all(gap_pct);
        repeat (4) @(negedge CLK);
        check({nm, "_pending"}, exp_q.size(), 0);
        check({nm, "_drop_cnt"}, int'(DROP_CNT), md);
        check({nm, "_loss_cnt"}, int'(LOSS_CNT), ml);
        check({nm, "_state_mon"}, int'(state_mon), ms);
        check({nm, "_sync_found"}, int'(SYNC_FOUND), (ms == 2) ? 1 : 0);
        exp_q.delete();
    endtask

    initial begin
        int ms, md, ml;
        RST       = 1'b0;
        DIN       = 8'd0;
        DIN_VALID = 1'b0;
        FIFO_ROOM = 11'd0;

        // Clean back-to-back stream: packets 3..10 written.
        build(10, 1'b0);
        run_scn("clean", 0);
        check("clean_writes", n_wr, 8 * PKT);

        // False candidate at payload offset 50 of packet 1.
        build(10, 1'b0);
        s_data[0]  = 8'h00;
        s_data[50] = 8'h47;
        run_scn("false_sync", 0);
        check("false_sync_writes", n_wr, 6 * PKT);

        // Single corrupted sync while locked.
        build(10, 1'b0);
        s_data[4 * PKT] = 8'h46;
        run_scn("one_bad", 0);
        check("one_bad_loss", int'(LOSS_CNT), 0);
        check("one_bad_writes", n_wr, 8 * PKT);

        // Three consecutive corrupted syncs; stream ends in the unlocked packet.
        build(7, 1'b0);
        s_data[4 * PKT] = 8'h46;
        s_data[5 * PKT] = 8'h46;
        s_data[6 * PKT] = 8'h46;
        run_scn("three_bad", 0);
        check("three_bad_writes", n_wr, 4 * PKT);
        check("three_bad_loss", int'(LOSS_CNT), 1);
        check("three_bad_state", int'(state_mon), 0);

        // Low FIFO room at one locked sync position.
        build(10, 1'b0);
        s_room[4 * PKT] = 11'd100;
        run_scn("low_room", 0);
        check("low_room_drop", int'(DROP_CNT), 1);
        check("low_room_writes", n_wr, 7 * PKT);

        // Random valid gaps on a clean stream.
        build(10, 1'b0);
        run_scn("gaps", 40);
        check("gaps_writes", n_wr, 8 * PKT);

        // Reset asserted at byte 90 of a locked packet.
        build(5, 1'b0);
        while (s_data.size() > 4 * PKT + 90) begin
            void'(s_data.pop_back());
            void'(s_room.pop_back());
        end
        do_reset();
        model_run(ms, md, ml);
        drive_all(0);
        @(negedge CLK);
        #1;
        RST = 1'b0;
        #1;
        check_zero("mid_rst");
        check("mid_rst_pending", exp_q.size(), 0);
        exp_q.delete();
        build(6, 1'b0);
        run_scn("relock", 0);
        check("relock_writes", n_wr, 4 * PKT);

        // Fully random: corrupted syncs, random room, gaps, free payload.
        for (int r = 0; r < 3; r++) begin
            build(12, 1'b1);
            for (int p = 0; p < 12; p++) begin
                if ($urandom_range(0, 99) < 15) s_data[p * PKT] = rnd_byte(1'b0);
                s_room[p * PKT] = 11'($urandom_range(100, 400));
            end
            run_scn($sformatf("rand%0d", r), 25);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
